// File: rtl/uart_rx_oversampler_if.sv
// Signal bundle between the UART receive front end and its consumer.
// The receiver owns the master view; the line driver / byte consumer owns the slave view.
interface uart_rx_oversampler_if #(
  parameter int NBIT_DATA = 8
);
  logic                 rx_bit;
  logic [NBIT_DATA-1:0] data_out;
  logic                 rx_done_tick;
  logic                 frame_error;
  logic                 s_tick;

  // rx_done_tick and frame_error are single-clock strobes with no back-pressure:
  // the consumer must capture data_out in the cycle rx_done_tick is high
  // (data_out also holds until the next good frame).
  modport master (
    input  rx_bit,
    output data_out, rx_done_tick, frame_error, s_tick
  );

  modport slave (
    output rx_bit,
    input  data_out, rx_done_tick, frame_error, s_tick
  );
endinterface

// File: rtl/uart_rx_oversampler.sv
// 8N1 UART receiver with internal oversampling baud tick, 2-flop input
// synchroniser, mid-bit sampling and framing-error / break handling.
module uart_rx_oversampler #(
   parameter int NBIT_DATA = 8,
   parameter int NUM_TICKS = 16,
   parameter int BAUD_RATE = 9600,
   parameter int CLK_FREQ  = 50000000
) (
   input  logic                  clk,
   input  logic                  reset,
   uart_rx_oversampler_if.master bus,
   output logic [2:0]            dbg_state
);

   localparam int DIV   = CLK_FREQ / (BAUD_RATE * NUM_TICKS);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int S_W   = $clog2(NUM_TICKS);
   localparam int N_W   = (NBIT_DATA > 1) ? $clog2(NBIT_DATA) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [S_W-1:0]   S_MID    = S_W'(NUM_TICKS / 2 - 1);
   localparam logic [S_W-1:0]   S_LAST   = S_W'(NUM_TICKS - 1);
   localparam logic [N_W-1:0]   N_LAST   = N_W'(NBIT_DATA - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   state_t               state;
   logic [DIV_W-1:0]     div_cnt;
   logic                 tick;
   logic [1:0]           sync;
   logic                 rx_s;
   logic [S_W-1:0]       s_cnt;
   logic [N_W-1:0]       n_cnt;
   logic [NBIT_DATA-1:0] shift;
   logic [NBIT_DATA-1:0] data_q;
   logic                 done_q;
   logic                 ferr_q;

   assign rx_s             = sync[1];
   assign bus.data_out     = data_q;
   assign bus.rx_done_tick = done_q;
   assign bus.frame_error  = ferr_q;
   assign bus.s_tick       = tick;
   assign dbg_state        = state;

   // Free-running: never realigned to a start edge, so sampling phase may be off by up to DIV clks.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
         tick    <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) sync <= 2'b11;
      else        sync <= {sync[0], bus.rx_bit};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ST_IDLE;
         s_cnt  <= '0;
         n_cnt  <= '0;
         shift  <= '0;
         data_q <= '0;
         done_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ferr_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state <= ST_START;
                  s_cnt <= '0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (s_cnt == S_MID) begin
                     s_cnt <= '0;
                     n_cnt <= '0;
                     state <= rx_s ? ST_IDLE : ST_DATA;
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (s_cnt == S_LAST) begin
                     s_cnt <= '0;
                     shift <= {rx_s, shift[NBIT_DATA-1:1]};
                     if (n_cnt == N_LAST) state <= ST_STOP;
                     else                 n_cnt <= n_cnt + 1'b1;
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               // Leaving at mid-stop-bit lets an immediately following start edge be caught.
               if (tick) begin
                  if (s_cnt == S_LAST) begin
                     if (rx_s) begin
                        data_q <= shift;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                     end else begin
                        ferr_q <= 1'b1;
                        state  <= ST_BREAK;
                     end
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            ST_BREAK: begin
               if (rx_s) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Randomised and directed bench for uart_rx_oversampler with a frame-level
// reference model feeding an expected-event queue checked by a monitor.
module tb_uart_rx_oversampler;

   localparam int NBIT      = 8;
   localparam int NTICKS    = 16;
   localparam int BAUD      = 9600;
   localparam int CLKF      = BAUD * NTICKS * 4;
   localparam int BIT_CLKS  = 64;
   localparam int LAT_MIN   = 595;
   localparam int LAT_MAX   = 8 * 64 + 64 + 40;

   logic       clk;
   logic       reset;
   logic [2:0] dbg_state;

   uart_rx_oversampler_if #(.NBIT_DATA(NBIT)) bus ();

   uart_rx_oversampler #(
      .NBIT_DATA(NBIT),
      .NUM_TICKS(NTICKS),
      .BAUD_RATE(BAUD),
      .CLK_FREQ (CLKF)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;

   // expected events: bit 8 = framing error, bits 7:0 = data_out required at the pulse
   logic [NBIT:0] exp_q[$];
   int            start_q[$];
   logic [NBIT-1:0] last_good;

   task automatic check(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // driver tasks
   task automatic drive_bit(input logic b);
      bus.rx_bit = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [NBIT-1:0] d, input logic stop_ok, input int hold_low);
      if (stop_ok) begin
         last_good = d;
         exp_q.push_back({1'b0, d});
      end else begin
         exp_q.push_back({1'b1, last_good});
      end
      start_q.push_back(cyc);
      drive_bit(1'b0);
      for (int i = 0; i < NBIT; i++) drive_bit(d[i]);
      drive_bit(stop_ok);
      if (!stop_ok) repeat (hold_low) @(negedge clk);
      bus.rx_bit = 1'b1;
   endtask

   task automatic idle(input int n);
      bus.rx_bit = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (reset && (bus.rx_done_tick || bus.frame_error)) begin
         logic [NBIT:0] e;
         int            st;
         if (bus.rx_done_tick && bus.frame_error) begin
            check("both_pulses", 1, 0);
         end else if (exp_q.size() == 0) begin
            check("unexpected_pulse", {bus.frame_error, bus.data_out}, 0);
         end else begin
            e  = exp_q.pop_front();
            st = start_q.pop_front();
            check(e[NBIT] ? "ferr_event" : "done_event",
                  int'({bus.frame_error, bus.data_out}), int'(e));
            vectors++;
            if ((cyc - st) < LAT_MIN || (cyc - st) > LAT_MAX) begin
               miscompares++;
               $display("FAIL latency: got %0d clks, expected %0d..%0d", cyc - st, LAT_MIN, LAT_MAX);
            end
         end
      end
   end

   initial begin
      int gap;
      int waited;
      int period;
      logic [NBIT-1:0] d;
      logic ok;

      last_good  = '0;
      reset      = 1'b0;
      bus.rx_bit = 1'b1;

      // 1: reset values and baud tick cadence
      repeat (5) @(negedge clk);
      check("rst_data_out", bus.data_out, 0);
      check("rst_done", bus.rx_done_tick, 0);
      check("rst_ferr", bus.frame_error, 0);
      check("rst_s_tick", bus.s_tick, 0);
      reset = 1'b1;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!bus.s_tick && waited < 8);
      vectors++;
      if (waited > 4) begin
         miscompares++;
         $display("FAIL first_tick: got %0d clks, expected <= 4", waited);
      end
      for (int k = 0; k < 5; k++) begin
         period = 0;
         do begin
            @(negedge clk);
            period++;
         end while (!bus.s_tick && period < 10);
         check("tick_period", period, 4);
      end
      idle(20);

      // 2: single frame
      send_frame(8'h55, 1'b1, 0);
      idle(50);
      check("data_55", bus.data_out, 8'h55);

      // 3: back-to-back frames
      send_frame(8'hA3, 1'b1, 0);
      send_frame(8'h0F, 1'b1, 0);
      idle(50);

      // 4: glitch then a good frame
      bus.rx_bit = 1'b0;
      repeat (12) @(negedge clk);
      idle(100);
      check("glitch_hold", bus.data_out, 8'h0F);
      send_frame(8'h3C, 1'b1, 0);
      idle(50);

      // 5: framing error with long break
      send_frame(8'h11, 1'b1, 0);
      send_frame(8'hFF, 1'b0, 20 * BIT_CLKS);
      idle(40);
      check("ferr_hold", bus.data_out, 8'h11);
      send_frame(8'h81, 1'b1, 0);
      idle(50);

      // 6: reset in the middle of data bit 4 aborts the frame
      bus.rx_bit = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 4; i++) drive_bit(logic'((8'hC7 >> i) & 1));
      bus.rx_bit = 1'b0;
      repeat (20) @(negedge clk);
      reset      = 1'b0;
      bus.rx_bit = 1'b1;
      @(negedge clk);
      reset     = 1'b1;
      last_good = '0;
      check("midrst_data_out", bus.data_out, 0);
      idle(3 * BIT_CLKS);
      check("midrst_quiet", bus.data_out, 0);
      send_frame(8'h7E, 1'b1, 0);
      idle(50);

      // randomised frames, gaps and framing errors
      for (int f = 0; f < 16; f++) begin
         d  = NBIT'($urandom_range(0, 255));
         ok = ($urandom_range(0, 4) != 0);
         send_frame(d, ok, ok ? 0 : $urandom_range(0, 300));
         gap = ok ? $urandom_range(0, 80) : $urandom_range(16, 80);
         if (gap > 0) idle(gap);
      end

      idle(200);
      check("queue_drained", exp_q.size(), 0);
      check("final_data_out", bus.data_out, last_good);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
